// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM encoding and operand-width helper for the
// iterative divider.
package seq_divider_pkg;
   localparam int N_DEF = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;
   function automatic int op_width(input int n);
      return 2 ** n;
   endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring trial subtract; shifts the next dividend bit into
// the partial remainder and keeps the difference only when it is non-negative.
module div_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] r,
   input  logic         q_msb,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] r_next,
   output logic         q_bit
);
   logic [W:0] rs, t;
   always_comb begin
      rs     = {r, q_msb};
      t      = rs - {1'b0, divisor};
      q_bit  = ~t[W];
      r_next = q_bit ? t[W-1:0] : rs[W-1:0];
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per clock;
// divide-by-zero short-circuits to a one-cycle result.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N = N_DEF,
   localparam int W = op_width(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);
   state_t state, nxt;
   logic [N-1:0] count;
   logic [W-1:0] r, r_next, q, dvs;
   logic q_bit, accept;

   // The remainder stays below the divisor, so only W bits need storing;
   // the guard bit lives inside div_step for the trial-subtract sign.
   div_step #(.W(W)) u_step (
      .r(r), .q_msb(q[W-1]), .divisor(dvs), .r_next(r_next), .q_bit(q_bit)
   );

   assign accept = start && !busy;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;

   always_comb
      nxt = state == CALC ? (count == '0 ? FIN : CALC)
          : accept ? (divisor == '0 ? FIN : CALC) : IDLE;

   always_comb begin
      busy = state == CALC;
      done = state == FIN;
   end

   // Results are loaded on the edge entering FIN so they are valid with done.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count       <= '0;
         r           <= '0;
         q           <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         count       <= '1;
         r           <= '0;
         q           <= dividend;
         dvs         <= divisor;
         div_by_zero <= divisor == '0;
         if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
         end
      end else if (busy) begin
         count <= count - 1'b1;
         r     <= r_next;
         q     <= {q[W-2:0], q_bit};
         if (count == '0) begin
            quotient  <= {q[W-2:0], q_bit};
            remainder <= r_next;
         end
      end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against a
// scoreboard of expected quotient/remainder/div-by-zero results.
module tb_seq_divider;
   import seq_divider_pkg::*;
   localparam int W = op_width(N_DEF);

   typedef struct {
      logic [W-1:0] a, b, q, r;
      logic         z;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   exp_t sb[$];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.N(N_DEF)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives start for one cycle from the current negedge and records the expected result.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      e.z = b == '0;
      e.q = b == '0 ? '1 : a / b;
      e.r = b == '0 ? a : a % b;
      sb.push_back(e);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the first negedge after accept; inj > 0 pulses an ignored 50/5 start at that cycle.
   task automatic wait_done(input int lat, input int inj);
      int n = 1;
      int nb = 0;
      exp_t e;
      logic [31:0] prod;
      while (done !== 1'b1 && n < 64) begin
         if (busy === 1'b1) nb++;
         if (n == inj) begin
            start    = 1'b1;
            dividend = 16'd50;
            divisor  = 16'd5;
         end
         @(negedge clk);
         n++;
         if (n == inj + 1) start = 1'b0;
      end
      check("done_seen", 32'(done), 32'd1);
      check("latency", n, lat);
      check("busy_cycles", nb, lat - 1);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("quotient", 32'(quotient), 32'(e.q));
         check("remainder", 32'(remainder), 32'(e.r));
         check("div_by_zero", 32'(div_by_zero), 32'(e.z));
         if (e.b != '0) begin
            prod = 32'(quotient) * 32'(e.b) + 32'(remainder);
            check("identity", prod, 32'(e.a));
            check("rem_lt_div", 32'(remainder < e.b), 32'd1);
         end
      end
   endtask

   initial begin
      int seen;
      logic [W-1:0] a, b;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      launch(16'd100, 16'd7);
      wait_done(17, 0);
      @(negedge clk);
      launch(16'hFFFF, 16'd1);
      wait_done(17, 0);
      @(negedge clk);
      launch(16'd5, 16'd9);
      wait_done(17, 0);
      @(negedge clk);
      launch(16'd1234, 16'd0);
      wait_done(1, 0);
      launch(16'd10, 16'd3);
      check("dbz_cleared", 32'(div_by_zero), 32'd0);
      check("dbz_q_held", 32'(quotient), 32'hFFFF);
      wait_done(17, 0);
      @(negedge clk);
      launch(16'd100, 16'd7);
      wait_done(17, 5);
      launch(16'd50, 16'd5);
      check("b2b_q_held", 32'(quotient), 32'd14);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done(17, 0);
      @(negedge clk);
      check("idle_after_b2b", 32'(busy), 32'd0);
      launch(16'd100, 16'd7);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_quotient", 32'(quotient), 32'd0);
      check("arst_remainder", 32'(remainder), 32'd0);
      check("arst_dbz", 32'(div_by_zero), 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("no_done_after_abort", seen, 0);
      launch(16'd100, 16'd7);
      wait_done(17, 0);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         a = W'($urandom);
         b = i % 2 == 0 ? W'($urandom_range(1, 65535)) : W'($urandom_range(1, 255));
         launch(a, b);
         wait_done(17, 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
